// File: rtl/mux4_pkg.sv
// Shared types and sizes for the 4-channel mux front end and its select path.
// The output slot is either EMPTY or FULL, and out_valid is that state bit.
package mux4_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH     = 4;
  localparam int SEL_W      = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: the first requester at or after ptr
// (mod 4) wins.
import mux4_pkg::*;

module rr_pick4 (
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output sel_t              gnt_idx,
  output logic              gnt_any
);

  logic [NUM_CH-1:0] req_rot;
  sel_t              offset;

  // Rotate the requests so that ptr lands on bit 0. The 2-bit index sum wraps
  // naturally mod 4.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr + sel_t'(gi)];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = sel_t'(i);
    end
  end

  assign gnt_any = |req_rot;
  assign gnt_idx = ptr + offset;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin front end for the 4:1 byte mux. It picks one valid channel per
// cycle and holds the winner in a single registered output slot.
import mux4_pkg::*;

module rr_mux4_arbiter #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] ch_data [NUM_CH];
  slot_state_t       state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  sel_t              sel_reg, sel_next;
  sel_t              ptr_reg, ptr_next;
  sel_t              gnt_idx;
  logic              gnt_any;
  logic              load;
  logic              take;

  assign ch_data[0] = a;
  assign ch_data[1] = b;
  assign ch_data[2] = c;
  assign ch_data[3] = d;

  rr_pick4 u_pick (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The slot can accept a byte when it is empty or is draining this cycle.
  assign load = (state_reg == EMPTY) || out_ready;
  assign take = load && gnt_any && !rst;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = take && (gnt_idx == sel_t'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    if (load) begin
      if (gnt_any) begin
        state_next = FULL;
        data_next  = ch_data[gnt_idx];
        sel_next   = gnt_idx;
        ptr_next   = gnt_idx + sel_t'(1);
      end else begin
        state_next = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed scenarios plus a random soak, all checked
// against a cycle-level reference model and an in-order scoreboard.
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  rr_mux4_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (din[0]),
    .b         (din[1]),
    .c         (din[2]),
    .d         (din[3]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_sel;
  int wait_cnt [4];
  int sb_data [$];
  int sb_ch [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant: the first valid channel scanning ptr, ptr+1, ... mod 4; -1 if none.
  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    sb_data.delete();
    sb_ch.delete();
  endtask

  // One clock: apply inputs, check handshake, advance the model, check the slot.
  task automatic cycle(input logic [3:0] v, input logic r, output int acc);
    int g;
    logic [3:0] exp_rdy;
    in_valid  = v;
    out_ready = r;
    #1;
    g = pick(v, m_ptr);
    acc = -1;
    exp_rdy = 4'b0;
    if (g >= 0 && (!m_valid || r)) exp_rdy = 4'b1 << g;
    check("in_ready", in_ready, exp_rdy);
    if (out_valid && r) begin
      if (sb_data.size() == 0) check("sb_extra_byte", 1, 0);
      else begin
        check("sb_data", out_data, sb_data.pop_front());
        check("sb_sel", out_sel, sb_ch.pop_front());
      end
    end
    if (!m_valid || r) begin
      if (g >= 0) begin
        acc = g;
        m_valid = 1;
        m_data = din[g];
        m_sel = g;
        m_ptr = (g + 1) % 4;
        sb_data.push_back(din[g]);
        sb_ch.push_back(g);
        check("wait_bound", (wait_cnt[g] <= 3), 1);
        wait_cnt[g] = 0;
        for (int ch = 0; ch < 4; ch++) if (ch != g && v[ch]) wait_cnt[ch]++;
      end else begin
        m_valid = 0;
      end
    end
    for (int ch = 0; ch < 4; ch++) if (!v[ch]) wait_cnt[ch] = 0;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_sel", out_sel, m_sel);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    logic [3:0] v;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    in_valid = 4'hF;
    #1;
    check("rst_in_ready", in_ready, 4'b0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    rst = 1'b0;
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;

    // Asynchronous reset mid-cycle while the slot is full
    cycle(4'b0001, 1'b1, acc);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_sel", out_sel, 0);
    check("arst_in_ready", in_ready, 4'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(4'b1010, 1'b1, acc);
    check("arst_first_sel", out_sel, 1);

    // Fair rotation with all channels valid
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, 1'b1, acc);
      check("rot_data", out_data, exp_seq[i]);
      check("rot_sel", out_sel, i % 4);
    end

    // Back-pressure: slot holds 8'h22 for three stalled cycles
    do_reset();
    cycle(4'hF, 1'b1, acc);
    cycle(4'hF, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 1'b0, acc);
      check("bp_data", out_data, 8'h22);
      check("bp_sel", out_sel, 1);
      check("bp_in_ready", in_ready, 4'b0);
    end
    cycle(4'hF, 1'b1, acc);
    check("bp_release_data", out_data, 8'h33);

    // Sparse single request on c, then wrap from ptr=3 with a and d valid
    do_reset();
    din[2] = 8'hA5;
    cycle(4'b0100, 1'b1, acc);
    check("sparse_valid", out_valid, 1);
    check("sparse_data", out_data, 8'hA5);
    check("sparse_sel", out_sel, 2);
    cycle(4'b0000, 1'b1, acc);
    check("sparse_empty", out_valid, 0);
    cycle(4'b1001, 1'b1, acc);
    check("wrap_first", out_sel, 3);
    cycle(4'b1001, 1'b1, acc);
    check("wrap_second", out_sel, 0);

    // Random soak; channels hold data and valid until granted
    do_reset();
    v = 4'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!v[ch] && $urandom_range(1, 0) == 1) begin
          v[ch] = 1'b1;
          din[ch] = 8'($urandom);
        end
      end
      cycle(v, ($urandom_range(3, 0) != 0), acc);
      if (acc >= 0) v[acc] = 1'b0;
    end
    check("sb_depth", sb_data.size(), m_valid ? 1 : 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
